// File: rtl/mod_mult_seq_pkg.sv
// Shared constants for the RSA square-and-multiply datapath: operand width
// and the modular multiplier state encoding.
package mod_mult_seq_pkg;

  // Operand width shared with the operand mux and the exponentiation controller
  localparam int RSA_WIDTH = 6;

  // Multiplier FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mod_mult_seq_if.sv
// Request/response bundle between the exponentiation controller (master)
// and the sequential modular multiplier (slave).
interface mod_mult_seq_if
  import mod_mult_seq_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] n;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             err;

  modport master (
    output start, a, b, n,
    input  busy, done, result, err
  );

  modport slave (
    input  start, a, b, n,
    output busy, done, result, err
  );

endinterface

// File: rtl/mod_add_reduce.sv
// One interleaved step: (2*p + addend) brought back below n with two
// conditional subtractions. With p < n and addend < n the sum is < 3n,
// so WIDTH+2 bits hold every intermediate without overflow.
module mod_add_reduce
  import mod_mult_seq_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] addend,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] p_next
);

  logic [WIDTH+1:0] n_ext;
  logic [WIDTH+1:0] sum_t;
  logic [WIDTH+1:0] red1_t;
  logic [WIDTH+1:0] red2_t;
  logic [1:0]       unused_hi;

  // Double, add, then subtract n at most twice
  always_comb begin
    n_ext  = {2'b00, n};
    sum_t  = {1'b0, p, 1'b0} + {2'b00, addend};
    red1_t = (sum_t >= n_ext)  ? (sum_t - n_ext)  : sum_t;
    red2_t = (red1_t >= n_ext) ? (red1_t - n_ext) : red1_t;
  end

  // Fully reduced value always fits in WIDTH bits; the top two are zero
  assign {unused_hi, p_next} = red2_t;

endmodule

// File: rtl/mod_mult_seq.sv
// Sequential interleaved modular multiplier: result = (a*b) mod n.
// Scans b MSB first, one bit per clock, keeping the accumulator below n.
module mod_mult_seq
  import mod_mult_seq_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  mod_mult_seq_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] n_r;
  logic [WIDTH-1:0] p_r;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] result_r;
  logic             err_r;

  logic             accept;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] p_next;

  // Operands the accumulator cannot be reduced against
  function automatic logic bad_operands(input logic [WIDTH-1:0] a_v,
                                        input logic [WIDTH-1:0] n_v);
    return (n_v == '0) || (a_v >= n_v);
  endfunction

  // A request is only taken when no operation is in flight
  assign accept = bus.start && (state != ST_RUN);

  // Conditional addend for the current bit of the multiplier
  assign addend = b_r[cnt] ? a_r : '0;

  mod_add_reduce #(
    .WIDTH (WIDTH)
  ) u_step (
    .p      (p_r),
    .addend (addend),
    .n      (n_r),
    .p_next (p_next)
  );

  // Operand capture on an accepted request; pure data, no reset needed
  always_ff @(posedge clk) begin
    if (accept) begin
      a_r <= bus.a;
      b_r <= bus.b;
      n_r <= bus.n;
    end
  end

  // FSM, bit counter, accumulator and held result
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      p_r      <= '0;
      cnt      <= '0;
      result_r <= '0;
      err_r    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (bad_operands(bus.a, bus.n)) begin
              state    <= ST_DONE;
              result_r <= '0;
              err_r    <= 1'b1;
            end else begin
              state <= ST_RUN;
              p_r   <= '0;
              cnt   <= CNT_W'(WIDTH - 1);
              err_r <= 1'b0;
            end
          end else if (state == ST_DONE) begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          p_r <= p_next;
          if (cnt == '0) begin
            result_r <= p_next;
            state    <= ST_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy   = (state == ST_RUN);
  assign bus.done   = (state == ST_DONE);
  assign bus.result = result_r;
  assign bus.err    = err_r;

endmodule

// File: tb/tb_mod_mult_seq.sv
// Directed bench for the sequential modular multiplier.
module tb_mod_mult_seq;

  localparam int W = 6;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  mod_mult_seq_if #(.WIDTH(W)) bus ();

  mod_mult_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present a request for exactly one edge
  task automatic launch(input int av, input int bv, input int nv);
    bus.a     = W'(av);
    bus.b     = W'(bv);
    bus.n     = W'(nv);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Edges until done is seen, plus busy cycles on the way; bounded
  task automatic wait_done(output int lat, output int busy_n);
    lat    = 0;
    busy_n = 0;
    while (!bus.done && lat < 20) begin
      if (bus.busy) busy_n++;
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input int av, input int bv,
                        input int nv, input int exp_res, input int exp_err);
    int lat;
    int busy_n;
    launch(av, bv, nv);
    wait_done(lat, busy_n);
    check({tag, "_lat"}, lat + 1, (exp_err != 0) ? 1 : W + 1);
    check({tag, "_res"}, int'(bus.result), exp_res);
    check({tag, "_err"}, int'(bus.err), exp_err);
  endtask

  initial begin
    int lat;
    int busy_n;
    int done_seen;
    int av;
    int bv;
    tests = 0;
    fails = 0;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.n = '0;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_result", int'(bus.result), 0);
    check("rst_err", int'(bus.err), 0);
    rst = 1'b0;
    tick();

    // Basic 5*7 mod 11 = 2; inputs scrambled after capture
    launch(5, 7, 11);
    bus.a = '0;
    bus.b = '0;
    bus.n = '0;
    wait_done(lat, busy_n);
    check("basic_lat", lat + 1, 7);
    check("basic_busy", busy_n, 6);
    check("basic_res", int'(bus.result), 2);
    check("basic_err", int'(bus.err), 0);
    tick();
    check("basic_done_pulse", int'(bus.done), 0);
    check("basic_hold", int'(bus.result), 2);

    // Max range and zero operands
    run_op("max", 62, 62, 63, 1, 0);
    run_op("a0", 0, 63, 63, 0, 0);
    run_op("b0", 9, 0, 13, 0, 0);

    // Operand errors
    run_op("n0", 17, 5, 0, 0, 1);
    run_op("a_ge_n", 12, 3, 11, 0, 1);
    tick();

    // Start during RUN is ignored
    launch(5, 7, 11);
    tick();
    tick();
    bus.a = 6'd1;
    bus.b = 6'd1;
    bus.n = 6'd2;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(lat, busy_n);
    check("ign_lat", lat + 3 + 1, 7);
    check("ign_res", int'(bus.result), 2);

    // Back-to-back start in the DONE cycle
    bus.a = 6'd3;
    bus.b = 6'd4;
    bus.n = 6'd5;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("b2b_busy", int'(bus.busy), 1);
    check("b2b_done", int'(bus.done), 0);
    wait_done(lat, busy_n);
    check("b2b_lat", lat + 1, 7);
    check("b2b_res", int'(bus.result), 2);
    tick();

    // Reset in RUN cycle 3
    launch(5, 7, 11);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", int'(bus.busy), 0);
    check("mid_rst_done", int'(bus.done), 0);
    check("mid_rst_result", int'(bus.result), 0);
    check("mid_rst_err", int'(bus.err), 0);
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done) done_seen++;
      tick();
    end
    check("mid_rst_no_done", done_seen, 0);
    run_op("after_rst", 5, 7, 11, 2, 0);

    // Sweep every modulus with random operands
    for (int nv = 1; nv < 64; nv++) begin
      av = int'($urandom_range(0, nv - 1));
      bv = int'($urandom_range(0, 63));
      launch(av, bv, nv);
      wait_done(lat, busy_n);
      check("sweep_lat", lat + 1, W + 1);
      check("sweep_res", int'(bus.result), (av * bv) % nv);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
